// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register for the FIR processor core: valid/ready payload hand-off,
// branch/jump redirect generation, VMAC accumulator and retired-instruction counter.
module ex_mem_stage #(
  parameter int         XLEN     = 32,
  parameter logic [4:0] OP_VMAC  = 5'd16,
  parameter logic [2:0] CTL_JAL  = 3'd5,
  parameter logic [2:0] CTL_JALR = 3'd6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_alu_out,
  input  logic            in_branch,
  input  logic [4:0]      in_alu_op,
  input  logic [2:0]      in_alu_ctl,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_store_data,
  input  logic [4:0]      in_rd,
  input  logic            in_reg_write,
  input  logic            in_mem_read,
  input  logic            in_mem_write,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_store_data,
  output logic [4:0]      out_rd,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush,
  output logic            misaligned,
  input  logic            accum_clear,
  output logic [XLEN-1:0] accum_data,
  output logic [31:0]     retired_count
);

  logic            accept;
  logic            is_jump;
  logic            take;
  logic [XLEN-1:0] target;

  // NOTE: in_ready is purely combinational; with no skid buffer the stage can only
  // take a new item when the slot is empty or drains this same cycle.
  // The cycle the redirect is visible, the instruction in execute is younger than
  // the branch and is being flushed, so it must not be accepted.
  assign in_ready = (!out_valid || out_ready) && !redirect_valid;
  assign accept   = in_valid && in_ready;
  assign is_jump  = (in_alu_ctl == CTL_JAL) || (in_alu_ctl == CTL_JALR);
  assign take     = accept && in_branch;
  assign flush    = redirect_valid;

  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    target = in_pc + in_imm;
    if (in_alu_ctl == CTL_JALR) begin
      target    = in_rs1 + in_imm;
      target[0] = 1'b0;
    end
  end

  // NOTE: reset is synchronous: rst_n is only looked at on the rising clock edge,
  // and all state updates use non-blocking assignments.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_rd         <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      misaligned     <= 1'b0;
      accum_data     <= '0;
      retired_count  <= '0;
    end else begin
      if (accept) begin
        out_valid      <= 1'b1;
        out_result     <= is_jump ? (in_pc + XLEN'(4)) : in_alu_out;
        out_store_data <= in_store_data;
        out_rd         <= in_rd;
        out_reg_write  <= in_reg_write;
        out_mem_read   <= in_mem_read;
        out_mem_write  <= in_mem_write;
        retired_count  <= retired_count + 32'd1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      redirect_valid <= take;
      misaligned     <= take && (target[1:0] != 2'b00);
      if (take) begin
        redirect_pc <= target;
      end

      if (accum_clear) begin
        accum_data <= '0;
      end else if (accept && (in_alu_op == OP_VMAC)) begin
        accum_data <= in_alu_out;
      end
    end
  end

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: a cycle-level reference model queues expected
// payloads and redirects; an independent monitor compares them as the DUT presents them.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_branch;
  logic [31:0] in_alu_out, in_pc, in_imm, in_rs1, in_store_data;
  logic [4:0]  in_alu_op, in_rd;
  logic [2:0]  in_alu_ctl;
  logic        in_reg_write, in_mem_read, in_mem_write;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_write, out_mem_read, out_mem_write;
  logic        redirect_valid, flush, misaligned, accum_clear;
  logic [31:0] redirect_pc, accum_data, retired_count;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_out(in_alu_out), .in_branch(in_branch), .in_alu_op(in_alu_op),
    .in_alu_ctl(in_alu_ctl), .in_pc(in_pc), .in_imm(in_imm), .in_rs1(in_rs1),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_store_data(out_store_data),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .misaligned(misaligned),
    .accum_clear(accum_clear), .accum_data(accum_data), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] result;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [2:0]  ctl_bits;
  } pay_t;

  typedef struct {
    logic [31:0] pc;
    logic        mis;
  } redir_t;

  pay_t   exp_q[$];
  redir_t rq[$];
  pay_t   front;
  redir_t r_exp;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state (what the stage should hold, in architectural terms).
  logic        m_valid, m_redirect;
  logic [31:0] m_accum, m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] alu, input logic br,
                       input logic [4:0] op, input logic [2:0] ctl,
                       input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1);
    in_valid      = v;
    in_alu_out    = alu;
    in_branch     = br;
    in_alu_op     = op;
    in_alu_ctl    = ctl;
    in_pc         = pc;
    in_imm        = imm;
    in_rs1        = rs1;
    in_store_data = $urandom;
    in_rd         = 5'($urandom_range(0, 31));
    in_reg_write  = 1'($urandom_range(0, 1));
    in_mem_read   = 1'($urandom_range(0, 1));
    in_mem_write  = 1'($urandom_range(0, 1));
  endtask

  // One clock: model-side checks at negedge, model update at posedge, return at posedge+1.
  task automatic cycle();
    logic        ready, acc;
    logic [31:0] tgt;
    pay_t        p;
    redir_t      rd_e;
    @(negedge clk);
    ready = (!m_valid || out_ready) && !m_redirect;
    if (rst_n) begin
      check("in_ready", {31'b0, in_ready}, {31'b0, ready});
      check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
      check("accum_data", accum_data, m_accum);
      check("retired_count", retired_count, m_count);
    end
    acc = rst_n && in_valid && ready;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0; m_redirect = 1'b0; m_accum = '0; m_count = '0;
      exp_q.delete();
      rq.delete();
    end else begin
      if (acc) begin
        p.result     = (in_alu_ctl == 3'd5 || in_alu_ctl == 3'd6) ? in_pc + 32'd4 : in_alu_out;
        p.store_data = in_store_data;
        p.rd         = in_rd;
        p.ctl_bits   = {in_reg_write, in_mem_read, in_mem_write};
        exp_q.push_back(p);
        m_count = m_count + 32'd1;
        m_valid = 1'b1;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
      m_redirect = acc && in_branch;
      if (m_redirect) begin
        tgt = (in_alu_ctl == 3'd6) ? ((in_rs1 + in_imm) & 32'hFFFF_FFFE) : in_pc + in_imm;
        rd_e.pc  = tgt;
        rd_e.mis = (tgt % 4) != 0;
        rq.push_back(rd_e);
      end
      if (accum_clear) m_accum = '0;
      else if (acc && in_alu_op == 5'd16) m_accum = in_alu_out;
    end
    #1;
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard queues.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out_valid", 32'd1, 32'd0);
        end else begin
          front = exp_q[0];
          check("out_result", out_result, front.result);
          check("out_store_data", out_store_data, front.store_data);
          check("out_rd", {27'b0, out_rd}, {27'b0, front.rd});
          check("out_ctl", {29'b0, out_reg_write, out_mem_read, out_mem_write},
                {29'b0, front.ctl_bits});
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (redirect_valid) begin
        if (rq.size() == 0) begin
          check("unexpected_redirect", 32'd1, 32'd0);
        end else begin
          r_exp = rq.pop_front();
          check("redirect_pc", redirect_pc, r_exp.pc);
          check("misaligned", {31'b0, misaligned}, {31'b0, r_exp.mis});
          check("flush", {31'b0, flush}, 32'd1);
        end
      end else begin
        check("idle_flush_misaligned", {30'b0, flush, misaligned}, 32'd0);
        if (rq.size() != 0) begin
          check("missing_redirect", 32'd0, 32'd1);
          rq.delete();
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    m_valid = 1'b0; m_redirect = 1'b0; m_accum = '0; m_count = '0;
    rst_n = 1'b0; out_ready = 1'b1; accum_clear = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);

    // 1. Reset, check reset state, then a plain ADD accept.
    cycle(); cycle();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_rd", {27'b0, out_rd}, 32'd0);
    check("rst_redirect", {29'b0, redirect_valid, flush, misaligned}, 32'd0);
    check("rst_accum", accum_data, 32'd0);
    check("rst_count", retired_count, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 32'h1234, 1'b0, 5'd0, 3'd0, 32'h10, 32'd0, 32'd0);
    cycle();
    drive(1'b0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();

    // 2. Backpressure: held payload, new item waits three cycles, then loads.
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 1'b0, 5'd1, 3'd0, 32'h20, 32'd0, 32'd0);
    cycle();
    drive(1'b1, 32'hBBBB_0002, 1'b0, 5'd2, 3'd0, 32'h24, 32'd0, 32'd0);
    repeat (3) cycle();
    out_ready = 1'b1;
    cycle();
    drive(1'b0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();

    // 3. Taken BEQ, then a younger instruction offered during the flush cycle.
    drive(1'b1, 32'd1, 1'b1, 5'd3, 3'd2, 32'h100, 32'h20, 32'd0);
    cycle();
    drive(1'b1, 32'h5555, 1'b0, 5'd0, 3'd0, 32'h104, 32'd0, 32'd0);
    cycle();
    cycle();
    drive(1'b0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();

    // 4. JALR to a misaligned target; link address goes out as the result.
    drive(1'b1, 32'hDEAD, 1'b1, 5'd0, 3'd6, 32'h40, 32'd4, 32'h203);
    cycle();
    drive(1'b0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle(); cycle();
    // JAL to an aligned target for contrast.
    drive(1'b1, 32'hBEEF, 1'b1, 5'd0, 3'd5, 32'h80, 32'hFFFF_FFF0, 32'h0);
    cycle();
    drive(1'b0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle(); cycle();

    // 5. VMAC chain, then clear beating a simultaneous VMAC.
    drive(1'b1, 32'd5, 1'b0, 5'd16, 3'd0, 32'h200, 32'd0, 32'd0);  cycle();
    drive(1'b1, 32'd12, 1'b0, 5'd16, 3'd0, 32'h204, 32'd0, 32'd0); cycle();
    drive(1'b1, 32'd20, 1'b0, 5'd16, 3'd0, 32'h208, 32'd0, 32'd0); cycle();
    accum_clear = 1'b1;
    drive(1'b1, 32'd99, 1'b0, 5'd16, 3'd0, 32'h20C, 32'd0, 32'd0); cycle();
    accum_clear = 1'b0;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle(); cycle();

    // 6. Counter wrap.
    force dut.retired_count = 32'hFFFF_FFFF;
    #1;
    release dut.retired_count;
    m_count = 32'hFFFF_FFFF;
    drive(1'b1, 32'h77, 1'b0, 5'd0, 3'd0, 32'h300, 32'd0, 32'd0);
    cycle();
    drive(1'b0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    cycle();
    check("count_wrapped", retired_count, 32'd0);

    // Reset while a payload is stalled and a redirect has just been issued.
    out_ready = 1'b0;
    drive(1'b1, 32'h1111, 1'b1, 5'd0, 3'd0, 32'h400, 32'h40, 32'd0);
    cycle();
    drive(1'b0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    out_ready = 1'b1;
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_redirect", {29'b0, redirect_valid, flush, misaligned}, 32'd0);
    cycle();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      out_ready   = ($urandom_range(0, 9) < 7);
      accum_clear = ($urandom_range(0, 9) == 0);
      drive(($urandom_range(0, 9) < 7), $urandom, ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 3) == 0) ? 5'd16 : 5'($urandom_range(0, 31)),
            3'($urandom_range(0, 7)), $urandom, $urandom, $urandom);
      cycle();
    end

    // Drain and confirm every expected item and redirect was observed.
    accum_clear = 1'b0;
    out_ready   = 1'b1;
    drive(1'b0, 32'd0, 1'b0, 5'd0, 3'd0, 32'd0, 32'd0, 32'd0);
    repeat (4) cycle();
    check("drain_payloads", exp_q.size(), 32'd0);
    check("drain_redirects", rq.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
